// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------+
// | load_store_unit: RISC-V style byte/half/word load-store sequencer.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module load_store_unit #(
  parameter int RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [9:0]  i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_misaligned,
  output logic [31:0] o_load_data,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [1:0]  o_mem_size,
  output logic [9:0]  o_mem_address,
  output logic [31:0] o_mem_writedata,
  input  logic [31:0] i_mem_readdata
);

  localparam logic [2:0] C_WAIT_LAST = 3'(RAM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [9:0]  r_addr;
  logic [31:0] r_store_data;
  logic        r_misaligned;
  logic [31:0] r_load_data;
  logic [2:0]  r_wait_cnt;
  logic        w_illegal;
  logic        w_last_wait;
  logic [31:0] w_shifted;
  logic [31:0] w_extended;

  // Size/alignment legality of the request presented at the inputs.
  always_comb begin
    w_illegal = 1'b0;
    case (i_funct3)
      3'b000, 3'b100: w_illegal = 1'b0;
      3'b001, 3'b101: w_illegal = i_addr[0];
      3'b010:         w_illegal = |i_addr[1:0];
      default:        w_illegal = 1'b1;
    endcase
    if (i_is_store && i_funct3[2]) begin
      w_illegal = 1'b1;
    end
  end

  assign w_last_wait = (r_state == S_WAIT) && (r_wait_cnt == C_WAIT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = w_illegal ? S_RESP : S_ACCESS;
      S_ACCESS: w_next = r_is_store ? S_RESP : S_WAIT;
      S_WAIT:   if (w_last_wait) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_shifted = i_mem_readdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_extended = w_shifted;
    case (r_funct3)
      3'b000:  w_extended = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_extended = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_extended = {24'd0, w_shifted[7:0]};
      3'b101:  w_extended = {16'd0, w_shifted[15:0]};
      default: w_extended = w_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_is_store   <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr       <= 10'd0;
      r_store_data <= 32'd0;
      r_misaligned <= 1'b0;
      r_load_data  <= 32'd0;
      r_wait_cnt   <= 3'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start) begin
        r_is_store   <= i_is_store;
        r_funct3     <= i_funct3;
        r_addr       <= i_addr;
        r_store_data <= i_store_data;
        r_misaligned <= w_illegal;
      end
      if (r_state == S_ACCESS) begin
        r_wait_cnt <= 3'd0;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 3'd1;
      end
      if (w_last_wait) begin
        r_load_data <= w_extended;
      end
    end
  end

  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = (r_state == S_RESP);
  assign o_misaligned    = r_misaligned;
  assign o_load_data     = r_load_data;
  assign o_mem_read      = (r_state == S_ACCESS) && !r_is_store;
  assign o_mem_write     = (r_state == S_ACCESS) && r_is_store;
  assign o_mem_size      = r_funct3[1:0];
  assign o_mem_address   = r_addr;
  assign o_mem_writedata = r_store_data << {r_addr[1:0], 3'b000};

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// +----------------------------------------------------------------------+
// | tb_load_store_unit: bench for load_store_unit at latencies 1 and 3.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [9:0]  addr = 10'd0;
  logic [31:0] sdata = 32'd0;
  logic [31:0] rdata = 32'd0;

  logic        busy [2];
  logic        done [2];
  logic        mis [2];
  logic        mrd [2];
  logic        mwr [2];
  logic [31:0] ld [2];
  logic [31:0] wd [2];
  logic [1:0]  msize [2];
  logic [9:0]  maddr [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    load_store_unit #(.RAM_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .i_start         (start),
      .i_is_store      (is_store),
      .i_funct3        (funct3),
      .i_addr          (addr),
      .i_store_data    (sdata),
      .o_busy          (busy[g]),
      .o_done          (done[g]),
      .o_misaligned    (mis[g]),
      .o_load_data     (ld[g]),
      .o_mem_read      (mrd[g]),
      .o_mem_write     (mwr[g]),
      .o_mem_size      (msize[g]),
      .o_mem_address   (maddr[g]),
      .o_mem_writedata (wd[g]),
      .i_mem_readdata  (rdata)
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        illegal;
    logic        st;
    logic [9:0]  a;
    logic [1:0]  sz;
    logic [31:0] wdat;
    logic [31:0] ldv;
    int          cdone0;
    int          cdone1;
  } exp_t;

  typedef struct {
    string       nm;
    logic        st;
    logic [2:0]  f3;
    logic [9:0]  a;
    logic [31:0] sd;
    logic [31:0] rd;
    logic        ill;
    logic [31:0] ldexp;
    logic [31:0] wdexp;
  } vec_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          rdc [2] = '{0, 0};
  int          wrc [2] = '{0, 0};
  int          total = 0;
  int          bad = 0;
  logic [31:0] ld_model = 32'd0;
  string       cur = "reset";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Scoreboard side: strobes and done pulses are matched to the queued expectation.
  task automatic mon(input int d);
    exp_t e;
    logic have;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (d == 0) ? q0[0] : q1[0];
    if (mrd[d] || mwr[d]) begin
      if (!have) begin
        chk($sformatf("%s_d%0d_stray_strobe", cur, d), {30'd0, mrd[d], mwr[d]}, 32'd0);
      end else begin
        if (mrd[d]) rdc[d]++;
        if (mwr[d]) wrc[d]++;
        chk($sformatf("%s_d%0d_addr", cur, d), {22'd0, maddr[d]}, {22'd0, e.a});
        chk($sformatf("%s_d%0d_size", cur, d), {30'd0, msize[d]}, {30'd0, e.sz});
        if (e.st) chk($sformatf("%s_d%0d_wdata", cur, d), wd[d], e.wdat);
      end
    end
    if (done[d]) begin
      if (!have) begin
        chk($sformatf("%s_d%0d_stray_done", cur, d), {31'd0, done[d]}, 32'd0);
      end else begin
        chk($sformatf("%s_d%0d_done_cycle", cur, d), cyc, (d == 0) ? e.cdone0 : e.cdone1);
        chk($sformatf("%s_d%0d_misaligned", cur, d), {31'd0, mis[d]}, {31'd0, e.illegal});
        chk($sformatf("%s_d%0d_load_data", cur, d), ld[d], e.ldv);
        chk($sformatf("%s_d%0d_reads", cur, d), rdc[d], (!e.illegal && !e.st) ? 1 : 0);
        chk($sformatf("%s_d%0d_writes", cur, d), wrc[d], (!e.illegal && e.st) ? 1 : 0);
        rdc[d] = 0;
        wrc[d] = 0;
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic flush();
    q0.delete();
    q1.delete();
    rdc = '{0, 0};
    wrc = '{0, 0};
  endtask

  task automatic wait_idle(input string nm);
    int budget = 0;
    while ((q0.size() + q1.size()) > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if ((q0.size() + q1.size()) > 0) begin
      chk($sformatf("%s_timeout", nm), q0.size() + q1.size(), 32'd0);
      flush();
    end
  endtask

  // Pushes the expectation, pulses start for one cycle; returns in the start+1 cycle.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [9:0] a,
                       input logic [31:0] sd, input logic [31:0] rd, input logic ill,
                       input logic [31:0] ldexp, input logic [31:0] wdexp, output int c0);
    exp_t e;
    @(posedge clk);
    #1;
    c0 = cyc;
    if (!ill && !st) ld_model = ldexp;
    e.illegal = ill;
    e.st      = st;
    e.a       = a;
    e.sz      = f3[1:0];
    e.wdat    = wdexp;
    e.ldv     = ld_model;
    e.cdone0  = c0 + (ill ? 1 : (st ? 2 : 3));
    e.cdone1  = c0 + (ill ? 1 : (st ? 2 : 5));
    q0.push_back(e);
    q1.push_back(e);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; sdata = sd; rdata = rd;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_reset(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_busy", nm, d), {31'd0, busy[d]}, 32'd0);
      chk($sformatf("%s_d%0d_done", nm, d), {31'd0, done[d]}, 32'd0);
      chk($sformatf("%s_d%0d_mis", nm, d), {31'd0, mis[d]}, 32'd0);
      chk($sformatf("%s_d%0d_strobes", nm, d), {30'd0, mrd[d], mwr[d]}, 32'd0);
      chk($sformatf("%s_d%0d_load_data", nm, d), ld[d], 32'd0);
      chk($sformatf("%s_d%0d_maddr", nm, d), {22'd0, maddr[d]}, 32'd0);
      chk($sformatf("%s_d%0d_wdata", nm, d), wd[d], 32'd0);
    end
  endtask

  vec_t vt[$];

  initial begin
    int c0;
    vt.push_back('{"SW",     1'b1, 3'b010, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0,        32'hDEADBEEF});
    vt.push_back('{"SB",     1'b1, 3'b000, 10'h013, 32'h000000A5, 32'h0,        1'b0, 32'h0,        32'hA5000000});
    vt.push_back('{"LB",     1'b0, 3'b000, 10'h012, 32'h0,        32'h12F03456, 1'b0, 32'hFFFFFFF0, 32'h0});
    vt.push_back('{"LBU",    1'b0, 3'b100, 10'h012, 32'h0,        32'h12F03456, 1'b0, 32'h000000F0, 32'h0});
    vt.push_back('{"LH_a1",  1'b0, 3'b001, 10'h001, 32'h0,        32'h55555555, 1'b1, 32'h0,        32'h0});
    vt.push_back('{"LHU",    1'b0, 3'b101, 10'h002, 32'h0,        32'h8001ABCD, 1'b0, 32'h00008001, 32'h0});
    vt.push_back('{"LH",     1'b0, 3'b001, 10'h002, 32'h0,        32'h8001ABCD, 1'b0, 32'hFFFF8001, 32'h0});
    vt.push_back('{"LW",     1'b0, 3'b010, 10'h004, 32'h0,        32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 32'h0});
    vt.push_back('{"SH",     1'b1, 3'b001, 10'h002, 32'hAAAA1234, 32'h0,        1'b0, 32'h0,        32'h12340000});
    vt.push_back('{"SW_a2",  1'b1, 3'b010, 10'h006, 32'h11111111, 32'h0,        1'b1, 32'h0,        32'h0});
    vt.push_back('{"SBU",    1'b1, 3'b100, 10'h000, 32'h22222222, 32'h0,        1'b1, 32'h0,        32'h0});
    vt.push_back('{"F011",   1'b0, 3'b011, 10'h000, 32'h0,        32'h33333333, 1'b1, 32'h0,        32'h0});
    vt.push_back('{"LB_a3",  1'b0, 3'b000, 10'h003, 32'h0,        32'h7F000000, 1'b0, 32'h0000007F, 32'h0});
    vt.push_back('{"LH_a0",  1'b0, 3'b001, 10'h000, 32'h0,        32'h0000FFFE, 1'b0, 32'hFFFFFFFE, 32'h0});
    vt.push_back('{"SB_a1",  1'b1, 3'b000, 10'h001, 32'h123456C3, 32'h0,        1'b0, 32'h0,        32'h3456C300});
    vt.push_back('{"F110",   1'b0, 3'b110, 10'h004, 32'h0,        32'h44444444, 1'b1, 32'h0,        32'h0});
    vt.push_back('{"LHU_a1", 1'b0, 3'b101, 10'h001, 32'h0,        32'h66666666, 1'b1, 32'h0,        32'h0});
    vt.push_back('{"SH_a3",  1'b1, 3'b001, 10'h003, 32'h77777777, 32'h0,        1'b1, 32'h0,        32'h0});
    vt.push_back('{"LBU_a1", 1'b0, 3'b100, 10'h001, 32'h0,        32'h00008000, 1'b0, 32'h00000080, 32'h0});
    vt.push_back('{"LB_a1",  1'b0, 3'b000, 10'h001, 32'h0,        32'h00008000, 1'b0, 32'hFFFFFF80, 32'h0});

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Reset while both instances sit in WAIT aborts the load.
    cur = "abort";
    issue(1'b0, 3'b010, 10'h008, 32'h0, 32'h11223344, 1'b0, 32'h11223344, 32'h0, c0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    flush();
    ld_model = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("abort_rst");
    repeat (6) @(posedge clk);
    #1;
    check_reset("abort_after");

    // A second start while busy is dropped; the monitor flags any extra done/strobe.
    cur = "ignored_start";
    issue(1'b0, 3'b010, 10'h00C, 32'h0, 32'hA5A55A5A, 1'b0, 32'hA5A55A5A, 32'h0, c0);
    @(posedge clk);
    #1;
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 10'h020; sdata = 32'h0BADF00D;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(cur);
    repeat (6) @(posedge clk);
    #1;
    chk("ignored_start_busy0", {31'd0, busy[0]}, 32'd0);
    chk("ignored_start_busy1", {31'd0, busy[1]}, 32'd0);

    foreach (vt[i]) begin
      cur = vt[i].nm;
      issue(vt[i].st, vt[i].f3, vt[i].a, vt[i].sd, vt[i].rd, vt[i].ill,
            vt[i].ldexp, vt[i].wdexp, c0);
      wait_idle(cur);
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
